// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and the harness around it: sweep control,
// the DUT stimulus/response pair, and the captured result.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [2**N_IN-1:0]   expected;
  logic                 dut_out;
  logic [N_IN-1:0]      dut_in;
  logic                 busy;
  logic                 done;
  // "table" is a reserved word, hence the longer name for the captured truth table.
  logic [2**N_IN-1:0]   captured_table;
  logic                 match;
  logic [N_IN-1:0]      first_mismatch;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, captured_table, match, first_mismatch
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, captured_table, match, first_mismatch
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a combinational block, holding each for SETTLE
// cycles, and assembles the sampled output into a truth table checked against a reference.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_sweeper_if.slave bus
);

  localparam int W  = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  // state | meaning
  // IDLE  | waiting for start; results of the last sweep held
  // SWEEP | driving idx onto the DUT, sampling on the last settle cycle
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    exp_q;
  logic [W-1:0]    tbl;
  logic            mm_seen;
  logic            busy;
  logic            done;
  logic            match;
  logic [N_IN-1:0] first_mm;
  logic            miss;

  assign miss = (bus.dut_out != exp_q[idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      exp_q    <= '0;
      tbl      <= '0;
      mm_seen  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      first_mm <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SWEEP;
            busy     <= 1'b1;
            idx      <= '0;
            cnt      <= '0;
            tbl      <= '0;
            exp_q    <= bus.expected;
            mm_seen  <= 1'b0;
            first_mm <= '0;
            match    <= 1'b0;
          end
        end
        SWEEP: begin
          if (cnt == CNT_LAST) begin
            tbl[idx] <= bus.dut_out;
            if (miss && !mm_seen) begin
              mm_seen  <= 1'b1;
              first_mm <= idx;
            end
            if (idx == '1) begin
              // idx doubles as the registered dut_in, so it returns to 0 for IDLE
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              idx   <= '0;
              match <= !(mm_seen || miss);
            end else begin
              idx <= idx + 1'b1;
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in         = idx;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.captured_table = tbl;
  assign bus.match          = match;
  assign bus.first_mismatch = first_mm;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: table of sweeps against a 3-input block, plus hand-written sequences
// for start-while-busy, back-to-back, mid-sweep reset and a 1-input corner instance.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) b3 ();
  truth_table_sweeper_if #(.N_IN(1)) b1 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  truth_table_sweeper #(.N_IN(1), .SETTLE(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  // Block under characterization: mode 0 -> out = idx in {1,2,3}, 1 -> const 1, 2 -> const 0
  always_comb begin
    b3.dut_out = 1'b0;
    case (mode)
      2'd0:    b3.dut_out = (b3.dut_in == 3'd1) || (b3.dut_in == 3'd2) || (b3.dut_in == 3'd3);
      2'd1:    b3.dut_out = 1'b1;
      default: b3.dut_out = 1'b0;
    endcase
  end
  assign b1.dut_out = ~b1.dut_in[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Caller is #1 after an edge; start is sampled at the next edge (E).
  task automatic sweep3(input string name, input logic [7:0] expv, input logic [1:0] mode_v,
                        input bit poke, input bit hold, input logic [7:0] tbl_x,
                        input bit match_x, input logic [2:0] first_x);
    bit trace_ok;
    trace_ok    = 1'b1;
    mode        = mode_v;
    b3.expected = expv;
    b3.start    = 1'b1;
    @(posedge clk); #1;
    b3.start    = 1'b0;
    b3.expected = ~expv;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        if (b3.busy !== 1'b1 || b3.done !== 1'b0 || b3.match !== 1'b0 ||
            b3.dut_in !== 3'(k / 2))
          trace_ok = 1'b0;
        if (k == 1 && b3.captured_table !== 8'h00) trace_ok = 1'b0;
        b3.start = poke && (k == 4 || k == 8);
        if (hold && k == 15) b3.start = 1'b1;
      end
    end
    check({name, " trace"},  {63'd0, trace_ok}, 64'd1);
    check({name, " done"},   {63'd0, b3.done}, 64'd1);
    check({name, " busy"},   {63'd0, b3.busy}, 64'd0);
    check({name, " dut_in"}, {61'd0, b3.dut_in}, 64'd0);
    check({name, " table"},  {56'd0, b3.captured_table}, {56'd0, tbl_x});
    check({name, " match"},  {63'd0, b3.match}, {63'd0, match_x});
    check({name, " first"},  {61'd0, b3.first_mismatch}, {61'd0, first_x});
  endtask

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] expv;
    logic [7:0] tbl;
    bit         match;
    logic [2:0] first;
  } vec_t;

  vec_t vecs[8];
  bit   done_seen;

  initial begin
    vecs[0] = '{"basic",      2'd0, 8'h0E, 8'h0E, 1'b1, 3'd0};
    vecs[1] = '{"mism_a0",    2'd0, 8'hA0, 8'h0E, 1'b0, 3'd1};
    vecs[2] = '{"mism_0f",    2'd0, 8'h0F, 8'h0E, 1'b0, 3'd0};
    vecs[3] = '{"mism_0c",    2'd0, 8'h0C, 8'h0E, 1'b0, 3'd1};
    vecs[4] = '{"one_fe",     2'd1, 8'hFE, 8'hFF, 1'b0, 3'd0};
    vecs[5] = '{"one_last",   2'd1, 8'h7F, 8'hFF, 1'b0, 3'd7};
    vecs[6] = '{"zero_ok",    2'd2, 8'h00, 8'h00, 1'b1, 3'd0};
    vecs[7] = '{"zero_last",  2'd2, 8'h80, 8'h00, 1'b0, 3'd7};

    b3.start = 1'b0; b3.expected = 8'h00;
    b1.start = 1'b0; b1.expected = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy",   {63'd0, b3.busy}, 64'd0);
    check("rst done",   {63'd0, b3.done}, 64'd0);
    check("rst dut_in", {61'd0, b3.dut_in}, 64'd0);
    check("rst table",  {56'd0, b3.captured_table}, 64'd0);
    check("rst match",  {63'd0, b3.match}, 64'd0);
    check("rst first",  {61'd0, b3.first_mismatch}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      sweep3(vecs[i].name, vecs[i].expv, vecs[i].mode, 1'b0, 1'b0,
             vecs[i].tbl, vecs[i].match, vecs[i].first);

    // Start pulses at relative edges 5 and 9 are ignored and not queued
    sweep3("poke", 8'h0E, 2'd0, 1'b1, 1'b0, 8'h0E, 1'b1, 3'd0);
    @(posedge clk); #1;
    check("poke done once", {63'd0, b3.done}, 64'd0);
    check("poke no requeue", {63'd0, b3.busy}, 64'd0);

    // Back-to-back: start held through the done cycle of the first sweep
    sweep3("b2b first", 8'hA0, 2'd0, 1'b0, 1'b1, 8'h0E, 1'b0, 3'd1);
    sweep3("b2b second", 8'hFF, 2'd1, 1'b0, 1'b0, 8'hFF, 1'b1, 3'd0);
    @(posedge clk); #1;
    check("b2b done once", {63'd0, b3.done}, 64'd0);

    // Reset between edges 7 and 8 of a sweep
    mode = 2'd0; b3.expected = 8'h0E; b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
    repeat (7) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst busy",   {63'd0, b3.busy}, 64'd0);
    check("arst dut_in", {61'd0, b3.dut_in}, 64'd0);
    check("arst table",  {56'd0, b3.captured_table}, 64'd0);
    check("arst match",  {63'd0, b3.match}, 64'd0);
    check("arst first",  {61'd0, b3.first_mismatch}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (b3.done === 1'b1 || b3.busy === 1'b1) done_seen = 1'b1;
    end
    check("arst no done", {63'd0, done_seen}, 64'd0);
    sweep3("after rst", 8'h0E, 2'd0, 1'b0, 1'b0, 8'h0E, 1'b1, 3'd0);

    // 1-input, SETTLE=1 instance with an inverter
    b1.expected = 2'b01; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    check("n1 busy",   {63'd0, b1.busy}, 64'd1);
    check("n1 dut_in0", {63'd0, b1.dut_in}, 64'd0);
    @(posedge clk); #1;
    check("n1 dut_in1", {63'd0, b1.dut_in}, 64'd1);
    check("n1 early done", {63'd0, b1.done}, 64'd0);
    @(posedge clk); #1;
    check("n1 done",  {63'd0, b1.done}, 64'd1);
    check("n1 table", {62'd0, b1.captured_table}, 64'd1);
    check("n1 match", {63'd0, b1.match}, 64'd1);
    b1.expected = 2'b10; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("n1 mm done",  {63'd0, b1.done}, 64'd1);
    check("n1 mm match", {63'd0, b1.match}, 64'd0);
    check("n1 mm first", {63'd0, b1.first_mismatch}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus/capture engine that drives every input combination into a combinational logic block and reads back its single output, assembling the block's truth table as a bit vector. It is the reading end of a truth-table-defined gate: the gate maps `{inN..in1}` to `out`, and this block recovers that mapping. It optionally checks the captured table against an expected table. It sits in the characterization and verification harness around synthesized netlists.

## Interface
- `N_IN`, 3: number of DUT inputs, 1..8; table width is `2**N_IN`.
- `SETTLE`, 2: cycles each combination is held before sampling, ≥1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request a sweep; honoured only in IDLE.
- `expected` in `2**N_IN`: reference table, bit i = expected out for index i; captured when `start` is accepted.
- `dut_out` in 1: DUT output.
- `dut_in` out `N_IN`: DUT inputs; bit 0 = in1 (LSB of index), bit `N_IN-1` = in`N_IN`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse, the sweep has completed.
- `table` out `2**N_IN`: captured truth table; bit i = `dut_out` sampled while `dut_in == i`.
- `match` out 1: `table == expected`; meaningful when `done` is high and afterwards.
- `first_mismatch` out `N_IN`: lowest mismatching index; 0 when `match`.

## Operation
- States: IDLE, SWEEP.
- **IDLE**
  - `dut_in = 0`, `busy = 0`.
  - `start = 1` moves the block to SWEEP. On the same edge: `idx <= 0`, `cnt <= 0`, `table <= 0`, `exp_q <= expected`, mismatch flag cleared, `first_mismatch <= 0`, `match <= 0`.
- **SWEEP**
  - `dut_in = idx`, registered. `cnt` counts 0..`SETTLE-1`.
  - When `cnt == SETTLE-1`, on that edge:
    - `table[idx] <= dut_out`.
    - If `dut_out != exp_q[idx]` and no earlier mismatch has been recorded, set the mismatch flag and load `first_mismatch <= idx`.
    - If `idx == 2**N_IN-1`: go to IDLE and pulse `done`. The `match` value loaded on this edge is not-(any mismatch, including this sample).
    - Otherwise: `idx <= idx+1`, `cnt <= 0`.
- `idx` has `N_IN` bits. Compare to all-ones for termination; `idx` never wraps.
- `start` while in SWEEP is ignored. It is not queued.
- `expected` changes during a sweep are ignored, because `exp_q` is used.
- `table`, `match` and `first_mismatch` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: `dut_in = 0`, `busy = 0`, `done = 0`, `table = 0`, `match = 0`, `first_mismatch = 0`, state IDLE.
- Reset asserted mid-sweep aborts immediately and asynchronously to the reset values. No `done` is produced.
- Treat `start` accepted at edge E as cycle 0:
  - `busy` rises after E.
  - `dut_in = i` is valid from edge `E + i*SETTLE` to edge `E + (i+1)*SETTLE`.
  - Sample i is taken at edge `E + (i+1)*SETTLE`.
- The last sample is at edge `E + 2**N_IN*SETTLE`. After that edge:
  - `busy = 0`, `done = 1` for exactly one cycle.
  - `table`, `match` and `first_mismatch` are final.
  - `dut_in` is 0.
- `start` high during the `done` cycle is accepted, since the state is IDLE. A back-to-back sweep begins with no gap cycle, and `done` still pulses for one cycle.
- `dut_out` is assumed to settle within `SETTLE` cycles of a `dut_in` change. It is sampled only on the last settle cycle.

## Test plan
- **Basic capture.** `N_IN=3`, `SETTLE=2`; DUT `out = (idx ∈ {1,2,3})`; `expected = 8'b00001110`; pulse `start` at edge 0.
  - `dut_in` steps 0..7 every 2 cycles.
  - `done` pulses after edge 16.
  - `table = 8'h0E`, `match = 1`, `first_mismatch = 0`.
- **Mismatch reporting.** Same DUT; `expected = 8'b10100000`.
  - `table = 8'h0E`, `match = 0`.
  - `first_mismatch = 1`: index 1 is the lowest difference, ahead of indices 2, 3, 5 and 7.
- **Start while busy.** Pulse `start` again at edges 5 and 9.
  - Neither pulse has any effect.
  - `done` occurs only after edge 16, and exactly once.
- **Back-to-back sweep.** Hold `start` high through the `done` cycle, with the DUT changed to constant 1 and `expected = 8'hFF`.
  - The second sweep begins immediately and `table` clears to 0.
  - The second `done` comes 16 cycles later with `table = 8'hFF`, `match = 1`.
- **Reset mid-sweep.** Assert `reset` between edges 7 and 8.
  - All outputs go to 0 without waiting for an edge.
  - No `done` pulse occurs.
  - A new `start` after reset yields the full basic-capture result.
- **Parameter corners.** `N_IN=1`, `SETTLE=1`, DUT = inverter, `expected = 2'b01`.
  - `done` after edge 2, `table = 2'b01`, `match = 1`.
